// File: rtl/fpu_pkg.sv
// Shared FPU wrapper definitions: fixed unit latencies, operand width and
// the response record carried through the response FIFOs.
package fpu_pkg;

    localparam int unsigned FMUL_LAT     = 2;
    localparam int unsigned FMUL_OVF_LAT = 1;
    localparam int unsigned FP32_W       = 32;
    localparam int unsigned FPU_TAG_W    = 4;

    typedef struct packed {
        logic [FP32_W-1:0]    data;
        logic                 ovf;
        logic [FPU_TAG_W-1:0] tag;
    } fp_rsp_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// First-word-fall-through synchronous FIFO for FPU responses.
// The head entry is visible on o_data whenever the FIFO is non-empty; o_data
// reads as zero while empty. o_count gives occupancy for credit accounting.
module fpu_rsp_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_full;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because o_data is masked when empty.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(i_push && w_full && !w_pop));

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Flow-control shell in front of the 2-stage fmul: credit-gated issue,
// latency tracking of valid/tag, ovf alignment and a response FIFO.
module fmul_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [31:0]       fmul_x1,
    output logic [31:0]       fmul_x2,
    input  logic [31:0]       fmul_y,
    input  logic              fmul_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_ovf,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [FP32_W-1:0] data;
        logic              ovf;
        logic [TAG_W-1:0]  tag;
    } rsp_t;

    logic [FMUL_LAT-1:0] r_v;
    logic [TAG_W-1:0]    r_t [FMUL_LAT];
    logic                r_ovf_q;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic [AW:0]         w_count;
    logic [AW+1:0]       w_used;
    rsp_t                w_in;
    rsp_t                w_head;

    assign w_accept = req_valid & req_ready;
    assign fmul_x1  = w_accept ? req_a : '0;
    assign fmul_x2  = w_accept ? req_b : '0;

    // Valid/tag pipes track each op through fmul; ovf is retimed one stage
    // because fmul reports it one cycle before the product.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v     <= '0;
            r_ovf_q <= 1'b0;
            for (int unsigned i = 0; i < FMUL_LAT; i++) r_t[i] <= '0;
        end else begin
            r_v     <= {r_v[FMUL_LAT-2:0], w_accept};
            r_ovf_q <= fmul_ovf;
            r_t[0]  <= req_tag;
            for (int unsigned i = 1; i < FMUL_LAT; i++) r_t[i] <= r_t[i-1];
        end
    end

    // Credits: ops in flight plus stored responses must leave a free slot.
    // Only registered state feeds this, so a same-cycle pop is not credited.
    always_comb begin
        w_used = (AW+2)'(w_count);
        for (int unsigned i = 0; i < FMUL_LAT; i++) w_used = w_used + (AW+2)'(r_v[i]);
        req_ready = (w_used < (AW+2)'(DEPTH));
    end

    assign w_push    = r_v[FMUL_LAT-1];
    assign w_in      = '{data: fmul_y, ovf: r_ovf_q, tag: r_t[FMUL_LAT-1]};
    assign rsp_valid = ~w_empty;
    assign w_pop     = rsp_valid & rsp_ready;

    fpu_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign rsp_data = w_head.data;
    assign rsp_ovf  = w_head.ovf;
    assign rsp_tag  = w_head.tag;
    assign busy     = (|r_v) | ~w_empty;

endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Bench for fmul_issue_ctrl with a behavioural 2-stage fmul attached.
module tb_fmul_issue_ctrl;

    localparam int unsigned TAG_W = 4;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      fmul_x1;
    logic [31:0]      fmul_x2;
    logic [31:0]      fmul_y;
    logic             fmul_ovf;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_ovf;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rsp_cnt = 0;

    typedef struct {
        logic [31:0]      data;
        logic             ovf;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             ovf;
    } vec_t;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fmul_issue_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .fmul_x1   (fmul_x1),
        .fmul_x2   (fmul_x2),
        .fmul_y    (fmul_y),
        .fmul_ovf  (fmul_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .rsp_tag   (rsp_tag),
        .busy      (busy)
    );

    // Behavioural fmul: truncating, flush-to-zero, {ovf, y}.
    function automatic logic [32:0] fmul_f(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [7:0]  ea, eb;
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        s  = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if (ea == 8'd0 || eb == 8'd0) return {1'b0, s, 31'd0};
        if (ea == 8'hFF || eb == 8'hFF) return {1'b0, s, 8'hFF, 23'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, e[7:0], m};
    endfunction

    logic [32:0] m_s1;
    always @(posedge clk) begin
        m_s1   <= fmul_f(fmul_x1, fmul_x2);
        fmul_y <= m_s1[31:0];
    end
    assign fmul_ovf = m_s1[32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Response monitor: sampled one time unit before each rising edge.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (rstn && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL stale_rsp: got tag %0h data %0h expected no response", rsp_tag, rsp_data);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_ovf",  64'(rsp_ovf),  64'(e.ovf));
                chk("rsp_tag",  64'(rsp_tag),  64'(e.tag));
                rsp_cnt++;
            end
        end
    end

    // Called at a falling edge; holds the request until accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] ed, input logic eo, output int acc_cyc);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        acc_cyc   = -1;
        for (int k = 0; k < 100; k++) begin
            #4;
            if (req_ready) begin
                chk("fmul_x1", 64'(fmul_x1), 64'(a));
                chk("fmul_x2", 64'(fmul_x2), 64'(b));
                sb.push_back('{data: ed, ovf: eo, tag: tag});
                acc_cyc = cyc;
                @(negedge clk);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("send_timeout", 64'd1, 64'd0);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 80; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int t0;
        int tv;
        int n_acc;
        int rc0;
        logic [31:0] bv;

        vecs[0] = '{a: 32'h80000000, b: 32'h40000000, tag: 4'd5, data: 32'h80000000, ovf: 1'b0};
        vecs[1] = '{a: 32'h7F800000, b: 32'h3F800000, tag: 4'd6, data: 32'h7F800000, ovf: 1'b0};
        vecs[2] = '{a: 32'h7F000000, b: 32'h7F000000, tag: 4'd7, data: 32'h7F800000, ovf: 1'b1};
        vecs[3] = '{a: 32'h00000000, b: 32'h3F800000, tag: 4'd8, data: 32'h00000000, ovf: 1'b0};
        vecs[4] = '{a: 32'h40000000, b: 32'h40000000, tag: 4'd9, data: 32'h40800000, ovf: 1'b0};
        vecs[5] = '{a: 32'hC0400000, b: 32'h40000000, tag: 4'hA, data: 32'hC0C00000, ovf: 1'b0};

        rstn = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0; rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(rsp_data),  64'd0);
        chk("rst_rsp_ovf",   64'(rsp_ovf),   64'd0);
        chk("rst_rsp_tag",   64'(rsp_tag),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_fmul_x1",   64'(fmul_x1),   64'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Single op latency: accept at T, rsp_valid first seen at T+3.
        rsp_ready = 1'b1;
        send(vecs[0].a, vecs[0].b, vecs[0].tag, vecs[0].data, vecs[0].ovf, t0);
        tv = -1;
        for (int k = 0; k < 10; k++) begin
            #4;
            if (rsp_valid) begin
                tv = cyc;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        chk("latency", 64'(tv - t0), 64'd3);
        drain();

        // Table vectors issued back-to-back (ovf entries adjacent to zero entry).
        for (int i = 0; i < 6; i++)
            send(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].data, vecs[i].ovf, t0);
        drain();

        // Backpressure: consumer stalled, exactly DEPTH accepts.
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 12; k++) begin
            bv = 32'h40000000 | 32'(n_acc);
            req_valid = 1'b1; req_a = 32'h3F800000; req_b = bv; req_tag = TAG_W'(n_acc);
            #4;
            if (req_ready) begin
                chk("bp_x1", 64'(fmul_x1), 64'h3F800000);
                sb.push_back('{data: bv, ovf: 1'b0, tag: TAG_W'(n_acc)});
                n_acc++;
            end else begin
                chk("bp_x1_gated", 64'(fmul_x1), 64'd0);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("bp_accepts", 64'(n_acc), 64'(DEPTH));
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        rc0 = rsp_cnt;
        rsp_ready = 1'b1;
        drain();
        chk("bp_rsp_count", 64'(rsp_cnt - rc0), 64'(DEPTH));

        // Streaming: one op per cycle, ready must never drop.
        rc0 = rsp_cnt;
        for (int i = 0; i < 32; i++) begin
            bv = {1'b0, 8'(100 + i), 23'(i * 12345)};
            req_valid = 1'b1; req_a = 32'h3F800000; req_b = bv; req_tag = TAG_W'(i);
            #4;
            chk("stream_ready", 64'(req_ready), 64'd1);
            if (req_ready) sb.push_back('{data: bv, ovf: 1'b0, tag: TAG_W'(i)});
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain();
        chk("stream_rsp_count", 64'(rsp_cnt - rc0), 64'd32);

        // Reset with two ops in the pipe and two in the FIFO.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(32'h3F800000, 32'h40400000, TAG_W'(i), 32'h40400000, 1'b0, t0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_busy",      64'(busy),      64'd0);
        chk("async_rst_req_ready", 64'(req_ready), 64'd1);
        chk("async_rst_rsp_data",  64'(rsp_data),  64'd0);
        sb.delete();
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #4;
            chk("post_rst_idle", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
